// File: rtl/cpu_defs_pkg.sv
// Register-file geometry shared by the writeback path and its neighbours.
// x0 is hardwired to zero, so writes to REG_ZERO are dropped.
package cpu_defs_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/wb_queue.sv
// Generic in-order synchronous FIFO of (addr, data) pairs; push visible at head next cycle.
// No internal overflow guard: the caller gates push on count < DEPTH and pop on count != 0.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic [PTR_W-1:0]              head,
  output logic [CNT_W-1:0]              count,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]  ent_data
);
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PTR_W-1:0]             head_q;
  logic [PTR_W-1:0]             tail_q;
  logic [CNT_W-1:0]             count_q;
  logic [PTR_W-1:0]             age;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately left out of reset; validity is derived from count.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  always_comb begin
    ent_valid = '0;
    age       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age          = PTR_W'(i) - head_q;
      ent_valid[i] = CNT_W'(age) < count_q;
    end
  end

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign head      = head_q;
  assign count     = count_q;
  assign ent_addr  = addr_q;
  assign ent_data  = data_q;
endmodule

// File: rtl/regfile_write_buffer.sv
// Queues writebacks and drains one per cycle into the register file (accept at edge N -> rf_we in N+1).
// wb_ready drops only when full or in reset; pending values are forwarded onto both read results.
module regfile_write_buffer
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] fwd_rd1,
  output logic [DATA_W-1:0] fwd_rd2,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);
  logic                         push;
  logic                         pop;
  logic [PTR_W-1:0]             head;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [PTR_W-1:0]             idx;

  assign wb_ready = !rst && (count < CNT_W'(DEPTH));
  // x0 writes complete the handshake but never occupy an entry.
  assign push     = wb_valid && wb_ready && (wb_addr != ADDR_W'(REG_ZERO));
  assign empty    = (count == '0);
  assign rf_we    = !empty && !rst;
  assign pop      = rf_we;

  wb_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (wb_addr),
    .push_data (wb_data),
    .pop       (pop),
    .head_addr (rf_addr),
    .head_data (rf_wd),
    .head      (head),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_rd1 = rf_rd1;
    fwd_rd2 = rf_rd2;
    idx     = '0;
    for (int a = 0; a < DEPTH; a++) begin
      idx = head + PTR_W'(a);
      if (ent_valid[idx] && (ent_addr[idx] == rd_addr1)) fwd_rd1 = ent_data[idx];
      if (ent_valid[idx] && (ent_addr[idx] == rd_addr2)) fwd_rd2 = ent_data[idx];
    end
    if (rd_addr1 == ADDR_W'(REG_ZERO)) fwd_rd1 = '0;
    if (rd_addr2 == ADDR_W'(REG_ZERO)) fwd_rd2 = '0;
  end
endmodule
